// File: rtl/minisrc_alu_pkg.sv
// Shared ALU-slice definitions: FSM state encoding, nibble width and op codes.
package minisrc_alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/busy/done handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, c_in, op,
        input  busy, done, result, c_out, ovf, zero
    );

    modport slave (
        input  start, a, b, c_in, op,
        output busy, done, result, c_out, ovf, zero
    );
endinterface

// File: rtl/FourBitCLA.sv
// Four-bit carry-lookahead slice with group generate/propagate outputs.
module FourBitCLA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out,
    output logic       g,
    output logic       p
);
    logic [3:0] gi;
    logic [3:0] pi;
    logic [3:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    // Fully expanded lookahead carries; no ripple between bits.
    assign c[0] = c_in;
    assign c[1] = gi[0] | (pi[0] & c_in);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c_in);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & c_in);

    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;

    assign c_out = g | (p & c_in);
    assign s     = pi ^ c;
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder processing one nibble per cycle through a single CLA slice.
// Optional subtract path enabled by NIBBLE_SERIAL_ADDER_SUB_EN.
module nibble_serial_adder
    import minisrc_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clr_n,
    nibble_serial_adder_if.slave  bus
);
    // WIDTH must be a positive multiple of NIBBLE_W.
    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e state;
    state_e state_nxt;
    logic   accept_c;
    logic   last_c;

    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    acc_nxt;
    logic [WIDTH-1:0]    b_eff;
    logic                cin_eff;
    logic                carry;
    logic                sign_a;
    logic                sign_b;
    logic [CNT_W-1:0]    cnt;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;
    logic                unused_g;
    logic                unused_p;

    logic                busy_q;
    logic                done_q;
    logic [WIDTH-1:0]    result_q;
    logic                c_out_q;
    logic                ovf_q;
    logic                zero_q;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic sub_c;

    // Subtraction is a + ~b + 1; c_in is ignored in that mode.
    assign sub_c   = (bus.op == OP_SUB);
    assign b_eff   = sub_c ? ~bus.b : bus.b;
    assign cin_eff = sub_c ? 1'b1 : bus.c_in;
`else
    logic unused_op;

    assign unused_op = bus.op;
    assign b_eff     = bus.b;
    assign cin_eff   = bus.c_in;
`endif

    FourBitCLA u_cla (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (b_sh[NIBBLE_W-1:0]),
        .c_in  (carry),
        .s     (slice_s),
        .c_out (slice_c),
        .g     (unused_g),
        .p     (unused_p)
    );

    // New sum nibble enters from the top; after NIBBLES shifts acc holds the full sum.
    assign acc_nxt = WIDTH'({slice_s, acc} >> NIBBLE_W);
    assign last_c  = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept_c  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-nibble datapath.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
        end else if (accept_c) begin
            a_sh   <= bus.a;
            b_sh   <= b_eff;
            carry  <= cin_eff;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= b_eff[WIDTH-1];
            cnt    <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= slice_c;
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            cnt   <= cnt + 1'b1;
        end
    end

    // Sticky result and flags, loaded only on the edge that enters DONE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if ((state == RUN) && last_c) begin
            result_q <= acc_nxt;
            c_out_q  <= slice_c;
            ovf_q    <= (sign_a == sign_b) && (acc_nxt[WIDTH-1] != sign_a);
            zero_q   <= (acc_nxt == '0);
        end
    end

    // Handshake outputs registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;

endmodule
